// File: rtl/inst_fetch_reg.sv
// Instruction fetch/decode front end for the 10-bit CPU.
// Fetches over a req/ack handshake, holds the word in IR, splits it into
// fields and sequences Ins_Buff so the immediate reaches the shared bus.
module inst_fetch_reg #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [15:0] IMM_MASK = 16'h00F0,
    parameter int unsigned IMM_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [9:0]        mem_data,
    input  logic              mem_ack,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [9:0]        ir_out,
    output logic [3:0]        opcode,
    output logic [1:0]        reg_sel,
    output logic [3:0]        imm_data,
    output logic              Ins_Buff,
    input  logic              exec_done,
    output logic              halted
);

    localparam int unsigned IR_W   = 10;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] S_FETCH  = 3'd1;
    localparam logic [ST_W-1:0] S_DECODE = 3'd2;
    localparam logic [ST_W-1:0] S_IMM    = 3'd3;
    localparam logic [ST_W-1:0] S_EXEC   = 3'd4;
    localparam logic [ST_W-1:0] S_HALT   = 3'd5;

    localparam logic [OP_W-1:0]   OP_HALT   = 4'hF;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(IMM_HOLD - 32'd1);

    logic [ST_W-1:0]   state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [IR_W-1:0]   ir_q,       ir_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic              mem_req_q,  mem_req_d;
    logic              ins_buff_q, ins_buff_d;
    logic              halted_q,   halted_d;

    logic [OP_W-1:0]   ir_op;

    assign ir_op = ir_q[9:6];

    // Next-state, pc/IR update and registered-output decode
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                hold_d = '0;
                if (ir_op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (IMM_MASK[ir_op]) begin
                    state_d = S_IMM;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_IMM: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = S_EXEC;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_EXEC: begin
                // A branch overrides the increment done at fetch time
                if (pc_load) begin
                    pc_d = pc_in;
                end
                if (exec_done) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it
        mem_req_d  = (state_d == S_FETCH);
        ins_buff_d = (state_d == S_IMM);
        halted_d   = (state_d == S_HALT);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            hold_q     <= '0;
            mem_req_q  <= 1'b0;
            ins_buff_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            hold_q     <= hold_d;
            mem_req_q  <= mem_req_d;
            ins_buff_q <= ins_buff_d;
            halted_q   <= halted_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = pc_q;
    assign ir_out   = ir_q;
    assign opcode   = ir_q[9:6];
    assign reg_sel  = ir_q[5:4];
    assign imm_data = ir_q[3:0];
    assign Ins_Buff = ins_buff_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_inst_fetch_reg.sv
// Randomized bench for inst_fetch_reg: an instruction-level model tracks
// pc/IR and predicts every output each cycle, plus literal pin checks.
module tb_inst_fetch_reg;

    localparam int unsigned ADDR_W   = 8;
    localparam logic [15:0] IMM_MASK = 16'h00F0;
    localparam int unsigned IMM_HOLD = 4;

    logic              clk;
    logic              rst;
    logic              run;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [9:0]        mem_data;
    logic              mem_ack;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_in;
    logic [9:0]        ir_out;
    logic [3:0]        opcode;
    logic [1:0]        reg_sel;
    logic [3:0]        imm_data;
    logic              Ins_Buff;
    logic              exec_done;
    logic              halted;

    inst_fetch_reg #(
        .ADDR_W   (ADDR_W),
        .IMM_MASK (IMM_MASK),
        .IMM_HOLD (IMM_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .ir_out    (ir_out),
        .opcode    (opcode),
        .reg_sel   (reg_sel),
        .imm_data  (imm_data),
        .Ins_Buff  (Ins_Buff),
        .exec_done (exec_done),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the program counter and IR must hold
    logic [ADDR_W-1:0] m_pc;
    logic [9:0]        m_ir;
    logic              m_halt;

    // Expected outputs for the current cycle
    logic              e_req;
    logic [ADDR_W-1:0] e_addr;
    logic [9:0]        e_ir;
    logic              e_buf;
    logic              e_halt;
    bit                chk_en;

    int vectors;
    int miscompares;

    // Observation-only monitor used for latency/length pins
    int cyc;
    int t_ack;
    int t_buf;
    int buf_cnt;
    logic buf_prev;

    initial begin
        cyc = 0; t_ack = 0; t_buf = 0; buf_cnt = 0; buf_prev = 1'b0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_req && mem_ack) t_ack = cyc;
        if (Ins_Buff && !buf_prev) t_buf = cyc;
        if (Ins_Buff) buf_cnt = buf_cnt + 1;
        buf_prev = Ins_Buff;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [9:0] ir_e;
        ir_e = e_ir;
        chk("mem_req",  32'(mem_req),  32'(e_req));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("ir_out",   32'(ir_out),   32'(ir_e));
        chk("opcode",   32'(opcode),   32'(ir_e[9:6]));
        chk("reg_sel",  32'(reg_sel),  32'(ir_e[5:4]));
        chk("imm_data", 32'(imm_data), 32'(ir_e[3:0]));
        chk("Ins_Buff", 32'(Ins_Buff), 32'(e_buf));
        chk("halted",   32'(halted),   32'(e_halt));
    endtask

    // Compare at the falling edge, then move to just after the next rising edge
    task automatic step();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic req, input logic bufe);
        e_req  = req;
        e_addr = m_pc;
        e_ir   = m_ir;
        e_buf  = bufe;
        e_halt = m_halt;
    endtask

    task automatic noise();
        run       = 1'($urandom);
        exec_done = 1'($urandom);
        pc_load   = 1'($urandom);
        pc_in     = ADDR_W'($urandom);
        mem_ack   = 1'($urandom);
        mem_data  = 10'($urandom);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock
    task automatic async_reset();
        #2;
        rst    = 1'b1;
        chk_en = 1'b0;
        #1;
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ir_out",   32'(ir_out),   32'd0);
        chk("rst_Ins_Buff", 32'(Ins_Buff), 32'd0);
        chk("rst_halted",   32'(halted),   32'd0);
        m_pc = '0; m_ir = '0; m_halt = 1'b0;
        run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
        pc_load = 1'b0; pc_in = '0; mem_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    // Sit in IDLE with run low for n cycles, then start fetching
    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_exp(1'b0, 1'b0);
            run     = 1'b0;
            mem_ack = 1'($urandom);
            step();
        end
        set_exp(1'b0, 1'b0);
        run = 1'b1;
        step();
    endtask

    // One instruction from FETCH through EXEC (or HALT / reset abort).
    // ld_mode: 0 no branch, 1 branch to ld_val on the done cycle, 2 random branches.
    task automatic do_instr(input logic [9:0] ins, input int ack_dly, input int done_dly,
                            input int ld_mode, input logic [ADDR_W-1:0] ld_val, input int rst_at);
        logic [3:0] op;
        for (int i = 0; i <= ack_dly; i++) begin
            set_exp(1'b1, 1'b0);
            noise();
            mem_ack  = (i == ack_dly);
            mem_data = (i == ack_dly) ? ins : 10'($urandom);
            step();
        end
        m_ir = ins;
        m_pc = m_pc + ADDR_W'(1);
        op   = ins[9:6];

        set_exp(1'b0, 1'b0);
        noise();
        step();

        if (op == 4'hF) begin
            m_halt = 1'b1;
            for (int i = 0; i < 20; i++) begin
                set_exp(1'b0, 1'b0);
                noise();
                run = 1'b1;
                mem_ack = (i % 2 == 0) ? 1'b1 : 1'($urandom);
                step();
            end
            return;
        end

        if (IMM_MASK[op]) begin
            for (int i = 0; i < int'(IMM_HOLD); i++) begin
                set_exp(1'b0, 1'b1);
                noise();
                if (i == rst_at) begin
                    async_reset();
                    return;
                end
                step();
            end
        end

        for (int i = 0; i <= done_dly; i++) begin
            set_exp(1'b0, 1'b0);
            noise();
            exec_done = (i == done_dly);
            case (ld_mode)
                1: begin
                    pc_load = (i == done_dly);
                    pc_in   = ld_val;
                end
                2: pc_load = ($urandom_range(0, 3) == 0);
                default: pc_load = 1'b0;
            endcase
            if (pc_load) m_pc = pc_in;
            step();
        end
    endtask

    initial begin
        int b0;
        vectors = 0; miscompares = 0;
        chk_en = 1'b0;
        rst = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_data = '0;
        exec_done = 1'b0; pc_load = 1'b0; pc_in = '0;
        m_pc = '0; m_ir = '0; m_halt = 1'b0;
        set_exp(1'b0, 1'b0);

        async_reset();
        go_idle(3);

        // First immediate instruction, ack after two wait cycles
        chk("pin_req_first",  32'(mem_req),  32'd1);
        chk("pin_addr_first", 32'(mem_addr), 32'd0);
        b0 = buf_cnt;
        do_instr(10'b0100_01_1010, 2, 1, 0, '0, -1);
        chk("pin_ack_to_buf", 32'(t_buf - t_ack), 32'd2);
        chk("pin_buf_len",    32'(buf_cnt - b0),  32'(IMM_HOLD));
        chk("pin_addr_1",     32'(mem_addr),      32'd1);
        chk("pin_opcode",     32'(opcode),        32'h4);
        chk("pin_reg_sel",    32'(reg_sel),       32'h1);
        chk("pin_imm",        32'(imm_data),      32'hA);

        // Non-immediate opcode: buffer never enabled
        b0 = buf_cnt;
        do_instr(10'b0010_00_0101, 0, 2, 0, '0, -1);
        chk("pin_no_buf", 32'(buf_cnt - b0), 32'd0);
        chk("pin_addr_2", 32'(mem_addr),     32'd2);

        // pc wrap at the top of the address space
        do_instr(10'b0001_10_0011, 1, 0, 1, 8'hFF, -1);
        chk("pin_addr_ff", 32'(mem_addr), 32'hFF);
        do_instr(10'b0011_11_1111, 0, 1, 0, '0, -1);
        chk("pin_addr_wrap", 32'(mem_addr), 32'h00);

        // Branch together with exec_done on the first EXEC cycle
        do_instr(10'b0010_01_0000, 0, 0, 1, 8'h3C, -1);
        chk("pin_addr_3c", 32'(mem_addr), 32'h3C);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            do_instr({4'($urandom_range(0, 14)), 6'($urandom)},
                     $urandom_range(0, 3), $urandom_range(0, 3), 2, '0, -1);
        end

        // Reset in the middle of an immediate hold
        do_instr(10'b0101_10_1010, 1, 0, 0, '0, 1);
        go_idle(4);
        chk("pin_restart_req",  32'(mem_req),  32'd1);
        chk("pin_restart_addr", 32'(mem_addr), 32'd0);

        for (int n = 0; n < 20; n++) begin
            do_instr({4'($urandom_range(0, 14)), 6'($urandom)},
                     $urandom_range(0, 3), $urandom_range(0, 3), 2, '0, -1);
        end

        // HALT opcode: stays halted, no further requests
        do_instr(10'h3C0, 2, 0, 0, '0, -1);
        chk("pin_halted",   32'(halted),  32'd1);
        chk("pin_halt_req", 32'(mem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
